bus_protocol_monitor: RTL and testbench
=======================================

// Module: bus_protocol_monitor
// PURPOSE
// - Synthesisable, multi-channel monitor for the req/readWrite_n/addressAck/writeAck/readAck bus protocol.
// - Instantiated alongside the bus-side target in the bus clock domain; tracks each channel's transaction state.
// - Flags protocol violations as registered error vectors and counts completed transactions per channel.
// PARAMETERS
// - NCH     1    number of independent channels monitored
// - TIMEOUT 64   max cycles allowed in WAIT_AACK or WAIT_DATA before a timeout error (>=2)
// - CNTW    16   width of each per-channel completed-transaction counter
// PORTS
// - i_clk          in   1         bus clock; all logic on rising edge
// - i_srst         in   1         synchronous reset, active-high
// - i_req          in   NCH       per-channel request
// - i_readWrite_n  in   NCH       per-channel direction: 1=read, 0=write
// - i_addressAck   in   NCH       per-channel address acknowledge (1-cycle pulse)
// - i_writeAck     in   NCH       per-channel write-data acknowledge (1-cycle pulse)
// - i_readAck      in   NCH       per-channel read-data acknowledge (1-cycle pulse)
// - i_errClear     in   1         clears all sticky error bits
// - i_cntClear     in   1         clears all transaction counters
// - o_errPulse     out  NCH*7     per-channel error bits, 1-cycle pulse; channel c at [c*7 +: 7]
// - o_errSticky    out  NCH*7     sticky copy of o_errPulse
// - o_txnCount     out  NCH*CNTW  completed transactions per channel, saturating
// - o_busy         out  NCH       channel FSM not in IDLE
// BEHAVIOUR
// - Reset: all FSMs IDLE, timers 0, o_errPulse/o_errSticky/o_txnCount/o_busy all 0.
// - Channels are fully independent; each has one FSM, one timer and one latched rnw bit.
// - Error bits: 0 REQ_DROP, 1 RNW_CHANGE, 2 SPURIOUS_AACK, 3 SPURIOUS_DACK, 4 TIMEOUT, 5 ACK_BOTH, 6 REQ_OVERLAP.
// - IDLE: req=1 -> latch rnw; if aack is high in the same cycle go WAIT_DATA, else go WAIT_AACK; timer=0.
// - IDLE: aack=1 with req=0 -> SPURIOUS_AACK. wack|rack -> SPURIOUS_DACK. Stay in IDLE.
// - WAIT_AACK: req=0 -> REQ_DROP, go IDLE.
// - WAIT_AACK: req=1 and rnw differs from latch -> RNW_CHANGE; latch the new rnw; stay.
// - WAIT_AACK: aack=1 with req=1 -> go WAIT_DATA, timer=0.
// - WAIT_AACK: wack|rack -> SPURIOUS_DACK.
// - WAIT_DATA: exactly one data ack, matching the latched rnw (rack for read, wack for write) -> go IDLE; o_txnCount+1.
// - WAIT_DATA: wrong-type ack -> SPURIOUS_DACK; stay. aack=1 -> SPURIOUS_AACK; stay. req=1 -> REQ_OVERLAP; stay.
// - Any state: wack&rack in the same cycle -> ACK_BOTH (also SPURIOUS_DACK if not in WAIT_DATA); no state change, no count.
// - Data ack is legal no earlier than the cycle after aack (an IDLE aack moves to WAIT_DATA, so same-cycle data ack -> SPURIOUS_DACK).
// - Several error bits may fire in one cycle; all are reported.
// - Latency: inputs sampled at edge N; o_errPulse, o_errSticky, o_txnCount and o_busy update at edge N+1 (registered).
// - o_errSticky: set-dominant. A new error in the same cycle as i_errClear leaves that bit set; all other bits clear.
// - o_txnCount: saturates at 2^CNTW-1. i_cntClear with a simultaneous completion -> counter = 0.
// - i_srst mid-transaction: channel returns to IDLE immediately; no error is reported.
// CONFIGURATION
// - BUSMON_TIMEOUT_EN defined:
//   - Timer increments each cycle in WAIT_AACK/WAIT_DATA and is width $clog2(TIMEOUT+1).
//   - Timeout fires when timer==TIMEOUT-1 and no progressing ack occurs that cycle: TIMEOUT error, channel -> IDLE, timer=0.
//   - An ack in the same cycle as expiry wins; no timeout is reported.
// - BUSMON_TIMEOUT_EN undefined: no timer logic; error bit 4 is tied 0; channels may wait indefinitely.
// TESTING
// - NCH=1, write: req=1,rnw=0 c0; aack c2; req=0 c3; wack c5 -> no errors, txnCount=1, o_busy high c1..c5.
// - Read with aack in the same cycle as req, rack 1 cycle later -> txnCount=1; rack in the aack cycle -> errPulse bit3, state stays WAIT_DATA.
// - req=1 c0, req=0 c2 before aack -> errPulse=7'b0000001 at c3, sticky holds; i_errClear at c5 clears it at c6.
// - TIMEOUT=8, BUSMON_TIMEOUT_EN: req held, no aack -> bit4 pulse exactly 8 cycles after entering WAIT_AACK, o_busy falls; undefined build -> no error.
// - NCH=2: ch0 write completes while ch1 gets wack&rack together in IDLE -> ch0 count=1, ch1 bits 3 and 5, channel fields isolated.
// - CNTW=2: 5 completed transactions -> count sticks at 3; i_cntClear with a simultaneous completion -> 0.

Source files
------------

// File: rtl/bus_protocol_monitor_if.sv
// Bus-side signal bundle for bus_protocol_monitor.
// master: the side that drives the bus and the clear strobes and reads status.
// slave:  the monitor, which observes the bus and reports status.
interface bus_protocol_monitor_if #(
  parameter int NCH  = 1,
  parameter int CNTW = 16
);
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      read_write_n;
  logic [NCH-1:0]      address_ack;
  logic [NCH-1:0]      write_ack;
  logic [NCH-1:0]      read_ack;
  logic                err_clear;
  logic                cnt_clear;
  logic [NCH*7-1:0]    err_pulse;
  logic [NCH*7-1:0]    err_sticky;
  logic [NCH*CNTW-1:0] txn_count;
  logic [NCH-1:0]      busy;

  modport master (
    output req, read_write_n, address_ack, write_ack, read_ack, err_clear, cnt_clear,
    input  err_pulse, err_sticky, txn_count, busy
  );

  modport slave (
    input  req, read_write_n, address_ack, write_ack, read_ack, err_clear, cnt_clear,
    output err_pulse, err_sticky, txn_count, busy
  );
endinterface

// File: rtl/bus_protocol_monitor.sv
// Multi-channel protocol monitor for the req / read_write_n / address_ack /
// write_ack / read_ack handshake. Each channel runs an independent FSM, reports
// violations as registered one-cycle error pulses plus a sticky copy, and
// counts completed transactions with a saturating counter.
// Error bit order per channel: 0 REQ_DROP, 1 RNW_CHANGE, 2 SPURIOUS_AACK,
// 3 SPURIOUS_DACK, 4 TIMEOUT, 5 ACK_BOTH, 6 REQ_OVERLAP.
// Optional feature macro: BUSMON_TIMEOUT_EN enables the per-channel wait
// timer; without it bit 4 is tied low and channels may wait forever.
module bus_protocol_monitor #(
  parameter int NCH     = 1,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  bus_protocol_monitor_if.slave bus
);

  localparam int NERR          = 7;
  localparam int E_REQ_DROP    = 0;
  localparam int E_RNW_CHANGE  = 1;
  localparam int E_SPUR_AACK   = 2;
  localparam int E_SPUR_DACK   = 3;
  localparam int E_TIMEOUT     = 4;
  localparam int E_ACK_BOTH    = 5;
  localparam int E_REQ_OVERLAP = 6;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("bus_protocol_monitor: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_AACK = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t              state_q [NCH];
  state_t              state_d [NCH];
  logic                rnw_q   [NCH];
  logic                rnw_d   [NCH];
  logic [NERR-1:0]     err_d   [NCH];
  logic [NCH-1:0]      done_d;
  logic [NCH-1:0]      busy_w;
  logic [NCH*NERR-1:0] pulse_q;
  logic [NCH*NERR-1:0] sticky_q;
  logic [NCH*CNTW-1:0] count_q;

`ifdef BUSMON_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  logic [TW-1:0] timer_q [NCH];
  logic [TW-1:0] timer_d [NCH];
`endif

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // A fresh error wins over a clear in the same cycle.
  function automatic logic [NERR-1:0] sticky_next(input logic [NERR-1:0] old_bits,
                                                  input logic [NERR-1:0] new_bits,
                                                  input logic            clr);
    return clr ? new_bits : (old_bits | new_bits);
  endfunction

  // Next-state, error and completion decode for every channel
  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    err_d   = '{default: '0};
    done_d  = '0;
`ifdef BUSMON_TIMEOUT_EN
    timer_d = '{default: '0};
`endif
    for (int c = 0; c < NCH; c++) begin
      logic req, rnw, aack, wack, rack, both, dack, match;
      req   = bus.req[c];
      rnw   = bus.read_write_n[c];
      aack  = bus.address_ack[c];
      wack  = bus.write_ack[c];
      rack  = bus.read_ack[c];
      both  = wack & rack;
      dack  = wack | rack;
      match = rnw_q[c] ? (rack & ~wack) : (wack & ~rack);

      case (state_q[c])
        IDLE: begin
          if (aack && !req) err_d[c][E_SPUR_AACK] = 1'b1;
          if (dack)         err_d[c][E_SPUR_DACK] = 1'b1;
          if (both) begin
            err_d[c][E_ACK_BOTH] = 1'b1;
          end else if (req) begin
            // Address ack in the request cycle skips straight to the data phase.
            rnw_d[c]   = rnw;
            state_d[c] = aack ? WAIT_DATA : WAIT_AACK;
          end
        end
        WAIT_AACK: begin
          if (dack) err_d[c][E_SPUR_DACK] = 1'b1;
          if (both) err_d[c][E_ACK_BOTH]  = 1'b1;
          if (!req) begin
            err_d[c][E_REQ_DROP] = 1'b1;
            if (!both) state_d[c] = IDLE;
          end else begin
            if (rnw != rnw_q[c]) begin
              err_d[c][E_RNW_CHANGE] = 1'b1;
              rnw_d[c]               = rnw;
            end
            if (aack && !both) state_d[c] = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (both)             err_d[c][E_ACK_BOTH]    = 1'b1;
          else if (dack && !match) err_d[c][E_SPUR_DACK] = 1'b1;
          if (aack)             err_d[c][E_SPUR_AACK]   = 1'b1;
          if (req)              err_d[c][E_REQ_OVERLAP] = 1'b1;
          if (match) begin
            state_d[c] = IDLE;
            done_d[c]  = 1'b1;
          end
        end
        default: state_d[c] = IDLE;
      endcase

`ifdef BUSMON_TIMEOUT_EN
      // Timer only runs while a wait state is held; any transition restarts it.
      if (state_q[c] != IDLE && state_d[c] == state_q[c]) begin
        if (timer_q[c] == T_LAST) begin
          err_d[c][E_TIMEOUT] = 1'b1;
          state_d[c]          = IDLE;
        end else begin
          timer_d[c] = timer_q[c] + T_ONE;
        end
      end
`else
      err_d[c][E_TIMEOUT] = 1'b0;
`endif
    end
  end

  // Channel FSM state, timers and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
`ifdef BUSMON_TIMEOUT_EN
        timer_q[c] <= '0;
`endif
      end
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
`ifdef BUSMON_TIMEOUT_EN
        timer_q[c] <= timer_d[c];
`endif
        pulse_q[c*NERR +: NERR]  <= err_d[c];
        sticky_q[c*NERR +: NERR] <= sticky_next(sticky_q[c*NERR +: NERR], err_d[c], bus.err_clear);
        if (bus.cnt_clear)
          count_q[c*CNTW +: CNTW] <= '0;
        else if (done_d[c])
          count_q[c*CNTW +: CNTW] <= sat_inc(count_q[c*CNTW +: CNTW]);
      end
    end
  end

  // Direction latch; only meaningful outside IDLE, where it has been loaded
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NCH; c++) rnw_q[c] <= rnw_d[c];
  end

  // Busy flag straight from the state register
  always_comb begin
    busy_w = '0;
    for (int c = 0; c < NCH; c++) busy_w[c] = (state_q[c] != IDLE);
  end

  assign bus.err_pulse  = pulse_q;
  assign bus.err_sticky = sticky_q;
  assign bus.txn_count  = count_q;
  assign bus.busy       = busy_w;

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Directed bench for bus_protocol_monitor (NCH=2, TIMEOUT=8, CNTW=2).
// Timeout expectations follow BUSMON_TIMEOUT_EN.
module tb_bus_protocol_monitor;
  localparam int NCH = 2, TIMEOUT = 8, CNTW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_protocol_monitor_if #(.NCH(NCH), .CNTW(CNTW)) bus ();

  bus_protocol_monitor #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .i_clk (clk),
    .i_srst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req = '0; bus.read_write_n = '0; bus.address_ack = '0;
    bus.write_ack = '0; bus.read_ack = '0; bus.err_clear = 1'b0; bus.cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 2'b11; bus.address_ack = 2'b11;
    step(); step();
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL reset_pulse: got %h want %h", bus.err_pulse, 14'h0); end
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL reset_sticky: got %h want %h", bus.err_sticky, 14'h0); end
    n_cmp++; if (bus.txn_count !== 4'h0) begin n_bad++; $display("FAIL reset_count: got %h want %h", bus.txn_count, 4'h0); end
    n_cmp++; if (bus.busy !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b want %b", bus.busy, 2'b00); end
    idle_bus(); rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    bus.req[0] = 1'b1; bus.read_write_n[0] = 1'b0; step();          // c0
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL write_busy_c1: got %b want %b", bus.busy, 2'b01); end
    step();                                                          // c1
    bus.address_ack[0] = 1'b1; step();                               // c2
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL write_pulse_aack: got %h want %h", bus.err_pulse, 14'h0); end
    bus.address_ack[0] = 1'b0; bus.req[0] = 1'b0; step();            // c3
    step();                                                          // c4
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL write_busy_c5: got %b want %b", bus.busy, 2'b01); end
    bus.write_ack[0] = 1'b1; step();                                 // c5
    bus.write_ack[0] = 1'b0;
    n_cmp++; if (bus.busy !== 2'b00) begin n_bad++; $display("FAIL write_busy_done: got %b want %b", bus.busy, 2'b00); end
    n_cmp++; if (bus.txn_count !== 4'b0001) begin n_bad++; $display("FAIL write_count: got %h want %h", bus.txn_count, 4'b0001); end
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL write_sticky: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_read();
    bus.req[0] = 1'b1; bus.read_write_n[0] = 1'b1; bus.address_ack[0] = 1'b1; step();
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL read_busy: got %b want %b", bus.busy, 2'b01); end
    bus.req[0] = 1'b0; bus.address_ack[0] = 1'b0; bus.read_ack[0] = 1'b1; step();
    n_cmp++; if (bus.txn_count !== 4'b0010) begin n_bad++; $display("FAIL read_count: got %h want %h", bus.txn_count, 4'b0010); end
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL read_pulse: got %h want %h", bus.err_pulse, 14'h0); end
    // data ack in the same cycle as the address ack
    bus.req[0] = 1'b1; bus.address_ack[0] = 1'b1; bus.read_ack[0] = 1'b1; step();
    n_cmp++; if (bus.err_pulse !== 14'h0008) begin n_bad++; $display("FAIL early_rack_pulse: got %h want %h", bus.err_pulse, 14'h0008); end
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL early_rack_busy: got %b want %b", bus.busy, 2'b01); end
    bus.req[0] = 1'b0; bus.address_ack[0] = 1'b0; step();
    bus.read_ack[0] = 1'b0; bus.read_write_n[0] = 1'b0;
    n_cmp++; if (bus.txn_count !== 4'b0011) begin n_bad++; $display("FAIL early_rack_count: got %h want %h", bus.txn_count, 4'b0011); end
    n_cmp++; if (bus.err_sticky !== 14'h0008) begin n_bad++; $display("FAIL early_rack_sticky: got %h want %h", bus.err_sticky, 14'h0008); end
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL read_sticky_clr: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_req_drop();
    bus.req[0] = 1'b1; step();                                       // c0
    step();                                                          // c1
    bus.req[0] = 1'b0; step();                                       // c2
    n_cmp++; if (bus.err_pulse !== 14'h0001) begin n_bad++; $display("FAIL drop_pulse: got %h want %h", bus.err_pulse, 14'h0001); end
    n_cmp++; if (bus.busy !== 2'b00) begin n_bad++; $display("FAIL drop_busy: got %b want %b", bus.busy, 2'b00); end
    step();                                                          // c3
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL drop_pulse_end: got %h want %h", bus.err_pulse, 14'h0); end
    step();                                                          // c4
    n_cmp++; if (bus.err_sticky !== 14'h0001) begin n_bad++; $display("FAIL drop_sticky_hold: got %h want %h", bus.err_sticky, 14'h0001); end
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;              // c5
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL drop_sticky_clr: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_timeout();
    logic [13:0] exp_p;
    logic [1:0]  exp_b;
    bus.req[0] = 1'b1; bus.read_write_n[0] = 1'b0; step();          // now in first WAIT_AACK cycle
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_p = 14'h0; exp_b = 2'b01;
`ifdef BUSMON_TIMEOUT_EN
      if (i == 8) begin exp_p = 14'h0010; exp_b = 2'b00; end
`endif
      n_cmp++; if (bus.err_pulse !== exp_p) begin n_bad++; $display("FAIL timeout_pulse_%0d: got %h want %h", i, bus.err_pulse, exp_p); end
      n_cmp++; if (bus.busy !== exp_b) begin n_bad++; $display("FAIL timeout_busy_%0d: got %b want %b", i, bus.busy, exp_b); end
    end
    bus.req[0] = 1'b0; step();
`ifdef BUSMON_TIMEOUT_EN
    exp_p = 14'h0;
`else
    exp_p = 14'h0001;
`endif
    n_cmp++; if (bus.err_pulse !== exp_p) begin n_bad++; $display("FAIL timeout_after: got %h want %h", bus.err_pulse, exp_p); end
    n_cmp++; if (bus.busy !== 2'b00) begin n_bad++; $display("FAIL timeout_after_busy: got %b want %b", bus.busy, 2'b00); end
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    // address ack exactly in the expiry cycle wins
    bus.req[0] = 1'b1; step();
    repeat (7) step();
    bus.address_ack[0] = 1'b1; step();
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL expiry_ack_pulse: got %h want %h", bus.err_pulse, 14'h0); end
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL expiry_ack_busy: got %b want %b", bus.busy, 2'b01); end
    bus.address_ack[0] = 1'b0; bus.req[0] = 1'b0; bus.write_ack[0] = 1'b1; step();
    bus.write_ack[0] = 1'b0;
    n_cmp++; if (bus.txn_count !== 4'b0011) begin n_bad++; $display("FAIL expiry_ack_count_sat: got %h want %h", bus.txn_count, 4'b0011); end
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL expiry_ack_sticky: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_two_channel();
    bus.cnt_clear = 1'b1; step(); bus.cnt_clear = 1'b0;
    n_cmp++; if (bus.txn_count !== 4'h0) begin n_bad++; $display("FAIL cnt_clear: got %h want %h", bus.txn_count, 4'h0); end
    bus.req[0] = 1'b1; bus.address_ack[0] = 1'b1;
    bus.write_ack[1] = 1'b1; bus.read_ack[1] = 1'b1; step();
    n_cmp++; if (bus.err_pulse !== 14'h1400) begin n_bad++; $display("FAIL two_ch_pulse: got %h want %h", bus.err_pulse, 14'h1400); end
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL two_ch_busy: got %b want %b", bus.busy, 2'b01); end
    bus.req[0] = 1'b0; bus.address_ack[0] = 1'b0; bus.write_ack = 2'b01; bus.read_ack = 2'b00; step();
    bus.write_ack = 2'b00;
    n_cmp++; if (bus.txn_count !== 4'b0001) begin n_bad++; $display("FAIL two_ch_count: got %h want %h", bus.txn_count, 4'b0001); end
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL two_ch_pulse_end: got %h want %h", bus.err_pulse, 14'h0); end
    n_cmp++; if (bus.err_sticky !== 14'h1400) begin n_bad++; $display("FAIL two_ch_sticky: got %h want %h", bus.err_sticky, 14'h1400); end
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_c;
    bus.cnt_clear = 1'b1; step(); bus.cnt_clear = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.req[0] = 1'b1; bus.address_ack[0] = 1'b1; bus.write_ack[0] = 1'b0; step();
      bus.req[0] = 1'b0; bus.address_ack[0] = 1'b0; bus.write_ack[0] = 1'b1; step();
      exp_c = (k > 3) ? 4'd3 : 4'(k);
      n_cmp++; if (bus.txn_count !== exp_c) begin n_bad++; $display("FAIL b2b_count_%0d: got %h want %h", k, bus.txn_count, exp_c); end
    end
    bus.req[0] = 1'b1; bus.address_ack[0] = 1'b1; bus.write_ack[0] = 1'b0; step();
    bus.req[0] = 1'b0; bus.address_ack[0] = 1'b0; bus.write_ack[0] = 1'b1; bus.cnt_clear = 1'b1; step();
    bus.write_ack[0] = 1'b0; bus.cnt_clear = 1'b0;
    n_cmp++; if (bus.txn_count !== 4'h0) begin n_bad++; $display("FAIL clear_with_done: got %h want %h", bus.txn_count, 4'h0); end
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL b2b_sticky: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_sticky_set_dominant();
    bus.write_ack[1] = 1'b1; step();
    n_cmp++; if (bus.err_pulse !== 14'h0400) begin n_bad++; $display("FAIL spur_dack_ch1: got %h want %h", bus.err_pulse, 14'h0400); end
    bus.write_ack[1] = 1'b0; bus.address_ack[0] = 1'b1; bus.err_clear = 1'b1; step();
    n_cmp++; if (bus.err_pulse !== 14'h0004) begin n_bad++; $display("FAIL spur_aack_ch0: got %h want %h", bus.err_pulse, 14'h0004); end
    n_cmp++; if (bus.err_sticky !== 14'h0004) begin n_bad++; $display("FAIL sticky_set_dom: got %h want %h", bus.err_sticky, 14'h0004); end
    bus.address_ack[0] = 1'b0; step(); bus.err_clear = 1'b0;
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL sticky_final_clr: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  task automatic test_reset_mid_txn();
    bus.req[0] = 1'b1; step();
    n_cmp++; if (bus.busy !== 2'b01) begin n_bad++; $display("FAIL mid_rst_busy_pre: got %b want %b", bus.busy, 2'b01); end
    rst = 1'b1; bus.req[0] = 1'b0; step();
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 2'b00) begin n_bad++; $display("FAIL mid_rst_busy: got %b want %b", bus.busy, 2'b00); end
    step();
    n_cmp++; if (bus.err_pulse !== 14'h0) begin n_bad++; $display("FAIL mid_rst_pulse: got %h want %h", bus.err_pulse, 14'h0); end
    n_cmp++; if (bus.err_sticky !== 14'h0) begin n_bad++; $display("FAIL mid_rst_sticky: got %h want %h", bus.err_sticky, 14'h0); end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_write();
    test_read();
    test_req_drop();
    test_timeout();
    test_two_channel();
    test_back_to_back();
    test_sticky_set_dominant();
    test_reset_mid_txn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
